// File: rtl/comb_bank_sequencer.sv
// Time-multiplexed sequencer for a bank of N comb filters: one shared multiplier,
// one shift pulse per delay line per sample, and an averaged bank output.
module comb_bank_sequencer #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned N     = 4,
  parameter int unsigned GW    = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sample_valid,
  input  logic [WIDTH-1:0]   sample_in,
  input  logic [N*WIDTH-1:0] taps,
  input  logic [N*GW-1:0]    gains,
  output logic [N-1:0]       fifo_en,
  output logic [WIDTH-1:0]   fifo_wdata,
  output logic               out_valid,
  output logic [WIDTH-1:0]   sample_out,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned KW    = (N > 1) ? LOG2N : 1;
  localparam int unsigned PW    = WIDTH + GW;
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned AW    = WIDTH + LOG2N;

  typedef enum logic [1:0] {IDLE, MUL, WR, OUT} state_t;

  state_t                 state;
  logic signed [WIDTH-1:0] x;
  logic [KW-1:0]           k;
  logic signed [AW-1:0]    acc;

  logic signed [WIDTH-1:0] tap_c;
  logic signed [GW-1:0]    gain_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [PW-1:0]    scaled_c;
  logic signed [SW-1:0]    sum_c;
  logic                    ovf_c;
  logic [WIDTH-1:0]        sat_c;
  logic [N-1:0]            onehot_c;

  // Feedback path for the comb currently selected by k
  assign tap_c    = taps[k*WIDTH +: WIDTH];
  assign gain_c   = gains[k*GW +: GW];
  assign prod_c   = PW'(tap_c) * PW'(gain_c);
  assign scaled_c = prod_c >>> (GW - 1);
  assign sum_c    = SW'(x) + SW'(scaled_c);

  // In range only when every bit above the result sign bit matches it
  assign ovf_c    = !((&sum_c[SW-1:WIDTH-1]) || !(|sum_c[SW-1:WIDTH-1]));
  assign sat_c    = ovf_c ? (sum_c[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}})
                          : sum_c[WIDTH-1:0];
  assign onehot_c = N'(1) << k;

  // fifo_en/fifo_wdata are loaded at the edge ending MUL so they are live during WR
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      x          <= '0;
      k          <= '0;
      acc        <= '0;
      fifo_en    <= '0;
      fifo_wdata <= '0;
      out_valid  <= 1'b0;
      sample_out <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      fifo_en   <= '0;
      out_valid <= 1'b0;
      if (sample_valid && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            x     <= sample_in;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          fifo_wdata <= sat_c;
          fifo_en    <= onehot_c;
          state      <= WR;
        end
        WR: begin
          acc <= acc + AW'(tap_c);
          if (k == KW'(N - 1)) begin
            state <= OUT;
          end else begin
            k     <= k + KW'(1);
            state <= MUL;
          end
        end
        OUT: begin
          sample_out <= WIDTH'(acc >>> LOG2N);
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_bank_sequencer.sv
// Directed vector bench for comb_bank_sequencer (WIDTH=12, N=4, GW=16).
module tb_comb_bank_sequencer;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned N     = 4;
  localparam int unsigned GW    = 16;
  localparam int          LAST  = 2 * N + 1;

  typedef struct packed {
    logic [WIDTH-1:0]        x;
    logic [N-1:0][WIDTH-1:0] tap;
    logic [N-1:0][GW-1:0]    gain;
    logic [N-1:0][WIDTH-1:0] wd;
    logic [WIDTH-1:0]        out;
  } vec_t;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               sample_valid = 1'b0;
  logic [WIDTH-1:0]   sample_in = '0;
  logic [N*WIDTH-1:0] taps = '0;
  logic [N*GW-1:0]    gains = '0;
  logic [N-1:0]       fifo_en;
  logic [WIDTH-1:0]   fifo_wdata;
  logic               out_valid;
  logic [WIDTH-1:0]   sample_out;
  logic               busy;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  comb_bank_sequencer #(.WIDTH(WIDTH), .N(N), .GW(GW)) dut (
    .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .sample_in(sample_in),
    .taps(taps), .gains(gains), .fifo_en(fifo_en), .fifo_wdata(fifo_wdata),
    .out_valid(out_valid), .sample_out(sample_out), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x, input int t0, input int t1, input int t2, input int t3,
                              input int g0, input int g1, input int g2, input int g3,
                              input int w0, input int w1, input int w2, input int w3,
                              input int o);
    vec_t v;
    v.x = WIDTH'(x);
    v.tap[0] = WIDTH'(t0); v.tap[1] = WIDTH'(t1); v.tap[2] = WIDTH'(t2); v.tap[3] = WIDTH'(t3);
    v.gain[0] = GW'(g0); v.gain[1] = GW'(g1); v.gain[2] = GW'(g2); v.gain[3] = GW'(g3);
    v.wd[0] = WIDTH'(w0); v.wd[1] = WIDTH'(w1); v.wd[2] = WIDTH'(w2); v.wd[3] = WIDTH'(w3);
    v.out = WIDTH'(o);
    return v;
  endfunction

  // Accept one sample and check every cycle up to out_valid; optional extra strobe
  task automatic run_vec(input vec_t v, input int strobe_at, input string nm);
    int exp_en;
    @(negedge clk);
    sample_in = v.x; taps = v.tap; gains = v.gain; sample_valid = 1'b1;
    for (int c = 0; c <= LAST; c++) begin
      @(posedge clk); #1;
      sample_valid = 1'b0;
      exp_en = ((c % 2 == 1) && (c < LAST)) ? (1 << ((c - 1) / 2)) : 0;
      chk({nm, " fifo_en"}, int'(fifo_en), exp_en);
      if (exp_en != 0)
        chk($sformatf("%s wdata%0d", nm, (c - 1) / 2), int'($signed(fifo_wdata)),
            int'($signed(v.wd[(c - 1) / 2])));
      chk($sformatf("%s out_valid c%0d", nm, c), int'(out_valid), (c == LAST) ? 1 : 0);
      chk($sformatf("%s busy c%0d", nm, c), int'(busy), (c < LAST) ? 1 : 0);
      if (c == LAST)
        chk({nm, " sample_out"}, int'($signed(sample_out)), int'($signed(v.out)));
      if (c == strobe_at) sample_valid = 1'b1;
    end
  endtask

  // Watch for stray activity while idle
  task automatic quiet(input int cycles, input string nm);
    int pulses = 0;
    int valids = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (fifo_en != '0) pulses++;
      if (out_valid) valids++;
    end
    chk({nm, " extra fifo_en"}, pulses, 0);
    chk({nm, " extra out_valid"}, valids, 0);
  endtask

  initial begin
    vecs[0] = mk(100, 0, 0, 0, 0, 'h4000, 'h4000, 'h4000, 'h4000, 100, 100, 100, 100, 0);
    vecs[1] = mk(100, 200, 0, 0, 0, 'h4000, 'h4000, 'h4000, 'h4000, 200, 100, 100, 100, 50);
    vecs[2] = mk(2000, 2000, 0, 0, 0, 'h7FFF, 'h4000, 'h4000, 'h4000, 2047, 2000, 2000, 2000, 500);
    vecs[3] = mk(-2048, -2048, 0, 0, 0, 'h7FFF, 'h4000, 'h4000, 'h4000,
                 -2048, -2048, -2048, -2048, -512);
    vecs[4] = mk(-5, -6, 5, -1000, 999, 'h4000, 'hC000, 'h2000, 'h8000, -8, -8, -255, -1004, -1);

    // Reset held with random stimulus
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      sample_valid = 1'($urandom);
      sample_in = WIDTH'($urandom);
      taps = {$urandom, $urandom};
      gains = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("rst fifo_en", int'(fifo_en), 0);
      chk("rst fifo_wdata", int'(fifo_wdata), 0);
      chk("rst out_valid", int'(out_valid), 0);
      chk("rst sample_out", int'(sample_out), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst overrun", int'(overrun), 0);
    end
    @(negedge clk);
    rstn = 1'b1;
    sample_valid = 1'b0;
    quiet(4, "post_rst idle");
    chk("post_rst busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], -1, $sformatf("vec%0d", i));
    chk("no overrun yet", int'(overrun), 0);

    // Second strobe three cycles after acceptance is ignored
    run_vec(vecs[1], 2, "overrun");
    quiet(12, "overrun tail");
    chk("overrun sticky", int'(overrun), 1);
    run_vec(vecs[0], -1, "after_overrun");
    chk("overrun still set", int'(overrun), 1);

    // Reset during comb 2's MUL cycle
    @(negedge clk);
    sample_in = vecs[2].x; taps = vecs[2].tap; gains = vecs[2].gain; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    chk("pre_abort busy", int'(busy), 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort fifo_en", int'(fifo_en), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort overrun", int'(overrun), 0);
    chk("abort sample_out", int'(sample_out), 0);
    chk("abort fifo_wdata", int'(fifo_wdata), 0);
    quiet(12, "abort tail");
    run_vec(vecs[4], -1, "post_abort");
    chk("post_abort overrun", int'(overrun), 0);

    // Strobe landing in the OUT cycle is also an overrun
    run_vec(vecs[0], 2 * N, "out_strobe");
    quiet(12, "out_strobe tail");
    chk("out_strobe overrun", int'(overrun), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comb_bank_sequencer.md
Name: comb_bank_sequencer

Overview:
Time-multiplexed controller for a bank of N comb filters, each built from one delay-line FIFO (WIDTH-bit, enable-to-shift, output = oldest entry). On each audio sample strobe it visits every comb in turn. For each comb it uses one shared multiplier to compute the feedback value, then pulses that delay line's enable with the new write value. It also accumulates the comb outputs into one averaged sample for the downstream allpass/reverb stage.

Parameters:
WIDTH, 12, signed sample width (audio in/out, delay line data)
N, 4, number of comb filters; must be a power of two, 1..16
GW, 16, gain width; signed Q1.(GW-1) format

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
sample_valid  input  1  one-cycle strobe; new input sample present
sample_in  input  WIDTH  signed input sample, valid with sample_valid
taps  input  N*WIDTH  delay line outputs; comb k at bits [k*WIDTH +: WIDTH]
gains  input  N*GW  per-comb feedback gain; comb k at [k*GW +: GW]; quasi-static
fifo_en  output  N  one-hot shift enable to the delay lines
fifo_wdata  output  WIDTH  shared write data bus to all delay line inputs
out_valid  output  1  one-cycle strobe; sample_out valid
sample_out  output  WIDTH  signed averaged comb bank output
busy  output  1  sequence in progress
overrun  output  1  sticky; a strobe arrived while busy

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State returns to IDLE.
  - fifo_en=0, fifo_wdata=0, out_valid=0, sample_out=0, busy=0, overrun=0, accumulator=0.
  - Reset wins over every other event, including mid-sequence. An aborted sequence produces no out_valid and no further fifo_en pulses.
- FSM states and transitions:
  - IDLE: on sample_valid, capture x=sample_in, clear the accumulator, set k=0, go to MUL.
  - MUL: register p = (taps[k] * gains[k]) >>> (GW-1). The product is full precision (WIDTH+GW bits). The shift is arithmetic, truncating toward negative infinity. Go to WR.
  - WR: fifo_wdata = sat_WIDTH(x + p). fifo_en[k]=1 for exactly this cycle. acc += taps[k], sign-extended. If k==N-1 go to OUT; otherwise k++ and go to MUL.
  - OUT: sample_out = acc >>> log2(N) (arithmetic). out_valid=1 for one cycle. Go to IDLE.
- Timing and latency:
  - taps[k] is read in MUL and again in WR of comb k, before that delay line shifts. The delay line updates at the edge ending WR.
  - Per sample: 1 IDLE-capture edge, then 2N cycles of MUL/WR, then 1 OUT cycle.
  - out_valid is high in the cycle 2N+1 edges after the edge that accepted sample_valid; latency is 2N+1 cycles.
  - fifo_en is one-hot or zero at all times. Each comb gets exactly one pulse per accepted sample, in order 0..N-1.
- Registered outputs:
  - fifo_wdata holds its last value outside WR.
  - sample_out holds its value until the next OUT state.
- busy: 1 in every state other than IDLE, including the OUT cycle.
- Overrun:
  - sample_valid while busy=1 is ignored. The sequence continues undisturbed and overrun is set.
  - overrun clears only on reset.
  - sample_valid in the OUT cycle is also an overrun. The strobe must arrive in IDLE.
- Saturation: sat_WIDTH clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The accumulator is WIDTH+log2(N) bits and cannot overflow.
- N=1: the sequence is a single MUL/WR pair; sample_out = taps[0].

Test Plan:
- Reset: hold rstn=0 for 3 cycles with random inputs -> all outputs 0. Release, sample_valid=0 -> fifo_en stays 0.
- Zero feedback (WIDTH=12, N=4): taps=0, gains=0x4000, sample_in=100 -> fifo_en pulses 0001,0010,0100,1000 on alternate cycles with fifo_wdata=100. Then out_valid with sample_out=0, 9 cycles after acceptance.
- Mixed taps: taps={0,0,0,200}(comb0=200), gain0=0x4000, sample_in=100 -> wdata comb0=200, combs1-3=100. sample_out=(200+0+0+0)>>2=50.
- Saturation: sample_in=2000, tap0=2000, gain0=0x7FFF -> 2000+1999 clamps to wdata 2047. Repeat with sample_in=-2048, tap0=-2048 -> wdata -2048.
- Overrun: second sample_valid 3 cycles after the first -> ignored, exactly 4 fifo_en pulses, one out_valid, overrun=1 until reset.
- Mid-sequence reset: rstn=0 during comb 2's MUL -> no further fifo_en, no out_valid. The next strobe after release runs a full clean sequence.
